pb_port_hub: RTL and testbench

Parametrised I/O port hub between the KCPSM6 (PicoBlaze) processor and the design's peripheral controllers (RTC, PS/2 keyboard, VGA). It replaces hand-written per-port decode with NUM_OUT write-registered output ports and NUM_IN registered-read input ports. It also adds new behaviour: per-port write/read pulses, k_write_strobe constant-port decode, and an interrupt controller with mask, pending status and write-1-to-clear. The hub sits directly on the processor's port bus; each peripheral connects to a slice of the flattened vectors.

---
 rtl/pb_port_hub.sv | 169 ++++++++++++++++
 tb/tb_pb_port_hub.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_port_hub.sv
// pb_port_hub
// Port hub sitting directly on the KCPSM6 port bus. It provides NUM_OUT
// write-registered output ports, NUM_IN registered-read input ports and a
// small edge-triggered interrupt controller with mask, pending status and
// write-1-to-clear.
//
// Ports
//   clk, reset       : single rising-edge clock, synchronous active-high reset
//   port_id          : processor port address
//   out_port         : processor write data
//   write_strobe     : OUTPUT qualifier, full 8-bit decode
//   k_write_strobe   : OUTPUTK qualifier, decodes port_id[3:0] only
//   read_strobe      : INPUT qualifier (only drives in_rd_pulse)
//   in_port          : registered read data to processor
//   interrupt        : registered interrupt request
//   interrupt_ack    : processor acknowledge pulse
//   out_regs         : output registers, port k at [k*N +: N]
//   out_wr_pulse     : one-cycle pulse per written output port
//   in_ports         : input port data, port k at [k*N +: N]
//   in_rd_pulse      : one-cycle pulse per read input port
//   irq_src          : rising-edge interrupt sources, synchronous to clk
//
// Reserved addresses (write_strobe only)
//   0xF0 : read pending (zero-extended)
//   0xF1 : read/write mask
//   0xF2 : write-1-to-clear pending, reads 0
module pb_port_hub #(
   parameter int N       = 8,
   parameter int NUM_OUT = 16,
   parameter int NUM_IN  = 8,
   parameter int NUM_IRQ = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           port_id,
   input  logic [N-1:0]         out_port,
   input  logic                 write_strobe,
   input  logic                 k_write_strobe,
   input  logic                 read_strobe,
   output logic [N-1:0]         in_port,
   output logic                 interrupt,
   input  logic                 interrupt_ack,
   output logic [NUM_OUT*N-1:0] out_regs,
   output logic [NUM_OUT-1:0]   out_wr_pulse,
   input  logic [NUM_IN*N-1:0]  in_ports,
   output logic [NUM_IN-1:0]    in_rd_pulse,
   input  logic [NUM_IRQ-1:0]   irq_src
);

   localparam logic [7:0] ADDR_IRQ_PEND = 8'hF0;
   localparam logic [7:0] ADDR_IRQ_MASK = 8'hF1;
   localparam logic [7:0] ADDR_IRQ_W1C  = 8'hF2;

   logic [NUM_OUT*N-1:0] out_regs_q,     out_regs_d;
   logic [NUM_OUT-1:0]   out_wr_pulse_q, out_wr_pulse_d;
   logic [NUM_IN-1:0]    in_rd_pulse_q,  in_rd_pulse_d;
   logic [N-1:0]         in_port_q,      in_port_d;
   logic                 interrupt_q,    interrupt_d;
   logic [NUM_IRQ-1:0]   pending_q,      pending_d;
   logic [NUM_IRQ-1:0]   mask_q,         mask_d;
   logic                 in_service_q,   in_service_d;
   logic [NUM_IRQ-1:0]   irq_dly_q,      irq_dly_d;

   logic [NUM_OUT-1:0]   out_hit;
   logic [NUM_IRQ-1:0]   irq_rise;
   logic [NUM_IRQ-1:0]   w1c_bits;
   logic                 irq_active;

   // OUTPUTK only carries a 4-bit constant address, so it can reach at most
   // ports 0..15 and never the reserved interrupt registers.
   always_comb begin
      out_hit = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (write_strobe && (port_id == 8'(k))) begin
            out_hit[k] = 1'b1;
         end
         if (k_write_strobe && (k < 16) && (port_id[3:0] == 4'(k))) begin
            out_hit[k] = 1'b1;
         end
      end
   end

   always_comb begin
      out_regs_d     = out_regs_q;
      out_wr_pulse_d = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (out_hit[k]) begin
            out_regs_d[k*N +: N] = out_port;
            out_wr_pulse_d[k]    = 1'b1;
         end
      end
   end

   // Read mux is refreshed every cycle from port_id so in_port is ready for
   // the second cycle of an INPUT regardless of read_strobe.
   always_comb begin
      in_port_d     = '0;
      in_rd_pulse_d = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (port_id == 8'(k)) begin
            in_port_d        = in_ports[k*N +: N];
            in_rd_pulse_d[k] = read_strobe;
         end
      end
      if (port_id == ADDR_IRQ_PEND) begin
         in_port_d[NUM_IRQ-1:0] = pending_q;
      end else if (port_id == ADDR_IRQ_MASK) begin
         in_port_d[NUM_IRQ-1:0] = mask_q;
      end
   end

   always_comb begin
      irq_dly_d  = irq_src;
      irq_rise   = irq_src & ~irq_dly_q;
      w1c_bits   = '0;
      mask_d     = mask_q;
      if (write_strobe && (port_id == ADDR_IRQ_W1C)) begin
         w1c_bits = out_port[NUM_IRQ-1:0];
      end
      if (write_strobe && (port_id == ADDR_IRQ_MASK)) begin
         mask_d = out_port[NUM_IRQ-1:0];
      end
      // A new edge beats a simultaneous clear of the same bit.
      pending_d  = (pending_q & ~w1c_bits) | irq_rise;
      irq_active = |(pending_q & mask_q);

      in_service_d = in_service_q;
      if (interrupt_ack) begin
         in_service_d = 1'b1;
      end else if (!irq_active) begin
         in_service_d = 1'b0;
      end

      // Ack is folded in so the request drops the cycle after the ack,
      // before in_service_q has had a chance to rise.
      interrupt_d = irq_active & ~in_service_q & ~interrupt_ack;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_regs_q     <= '0;
         out_wr_pulse_q <= '0;
         in_rd_pulse_q  <= '0;
         in_port_q      <= '0;
         interrupt_q    <= 1'b0;
         pending_q      <= '0;
         mask_q         <= '0;
         in_service_q   <= 1'b0;
         irq_dly_q      <= '0;
      end else begin
         out_regs_q     <= out_regs_d;
         out_wr_pulse_q <= out_wr_pulse_d;
         in_rd_pulse_q  <= in_rd_pulse_d;
         in_port_q      <= in_port_d;
         interrupt_q    <= interrupt_d;
         pending_q      <= pending_d;
         mask_q         <= mask_d;
         in_service_q   <= in_service_d;
         irq_dly_q      <= irq_dly_d;
      end
   end

   assign out_regs     = out_regs_q;
   assign out_wr_pulse = out_wr_pulse_q;
   assign in_rd_pulse  = in_rd_pulse_q;
   assign in_port      = in_port_q;
   assign interrupt    = interrupt_q;

endmodule

// File: tb/tb_pb_port_hub.sv
// Testbench for pb_port_hub: directed walk through the main use cases, then
// randomized bus traffic. A reference model computes the expected outputs
// for every cycle and queues them; a monitor compares after each edge.
module tb_pb_port_hub;

   localparam int N       = 8;
   localparam int NUM_OUT = 16;
   localparam int NUM_IN  = 8;
   localparam int NUM_IRQ = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [7:0]           port_id;
   logic [N-1:0]         out_port;
   logic                 write_strobe;
   logic                 k_write_strobe;
   logic                 read_strobe;
   logic [N-1:0]         in_port;
   logic                 interrupt;
   logic                 interrupt_ack;
   logic [NUM_OUT*N-1:0] out_regs;
   logic [NUM_OUT-1:0]   out_wr_pulse;
   logic [NUM_IN*N-1:0]  in_ports;
   logic [NUM_IN-1:0]    in_rd_pulse;
   logic [NUM_IRQ-1:0]   irq_src;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   pb_port_hub #(.N(N), .NUM_OUT(NUM_OUT), .NUM_IN(NUM_IN), .NUM_IRQ(NUM_IRQ)) dut (
      .clk            (clk),
      .reset          (reset),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .in_port        (in_port),
      .interrupt      (interrupt),
      .interrupt_ack  (interrupt_ack),
      .out_regs       (out_regs),
      .out_wr_pulse   (out_wr_pulse),
      .in_ports       (in_ports),
      .in_rd_pulse    (in_rd_pulse),
      .irq_src        (irq_src)
   );

   typedef struct {
      logic [NUM_OUT*N-1:0] regs;
      logic [NUM_OUT-1:0]   wrp;
      logic [NUM_IN-1:0]    rdp;
      logic [N-1:0]         inp;
      logic                 irq;
   } exp_t;

   exp_t sb[$];

   // Reference model state: what the hub should hold after the next edge.
   logic [N-1:0]       m_out [NUM_OUT];
   logic [NUM_OUT-1:0] m_wrp   = '0;
   logic [NUM_IN-1:0]  m_rdp   = '0;
   logic [N-1:0]       m_inp   = '0;
   logic               m_irq   = 1'b0;
   logic [NUM_IRQ-1:0] m_pend  = '0;
   logic [NUM_IRQ-1:0] m_mask  = '0;
   logic               m_insvc = 1'b0;
   logic [NUM_IRQ-1:0] m_prev  = '0;

   task automatic model_update();
      int p;
      logic [NUM_IRQ-1:0] clr;
      logic [NUM_IRQ-1:0] rises;
      logic               want;
      p = int'(port_id);
      if (reset) begin
         for (int k = 0; k < NUM_OUT; k++) m_out[k] = '0;
         m_wrp = '0; m_rdp = '0; m_inp = '0; m_irq = 1'b0;
         m_pend = '0; m_mask = '0; m_insvc = 1'b0; m_prev = '0;
         return;
      end
      m_wrp = '0;
      if (write_strobe && p < NUM_OUT) begin
         m_out[p] = out_port;
         m_wrp[p] = 1'b1;
      end
      if (k_write_strobe && (p % 16) < NUM_OUT) begin
         m_out[p % 16] = out_port;
         m_wrp[p % 16] = 1'b1;
      end
      m_rdp = '0;
      if (read_strobe && p < NUM_IN) m_rdp[p] = 1'b1;
      if (p < NUM_IN)       m_inp = in_ports[p*N +: N];
      else if (p == 'hF0)   m_inp = N'(m_pend);
      else if (p == 'hF1)   m_inp = N'(m_mask);
      else                  m_inp = '0;
      // interrupt and in_service are decided from the state before this edge
      want  = (m_pend & m_mask) != 0;
      m_irq = want && !m_insvc && !interrupt_ack;
      if (interrupt_ack)  m_insvc = 1'b1;
      else if (!want)     m_insvc = 1'b0;
      clr    = (write_strobe && p == 'hF2) ? out_port[NUM_IRQ-1:0] : '0;
      rises  = irq_src & ~m_prev;
      m_pend = (m_pend & ~clr) | rises;
      if (write_strobe && p == 'hF1) m_mask = out_port[NUM_IRQ-1:0];
      m_prev = irq_src;
   endtask

   // Present the current inputs to the model, queue the expectation, then
   // let the DUT take the edge. Inputs change only 2 time units after edges.
   task automatic step();
      exp_t e;
      model_update();
      for (int k = 0; k < NUM_OUT; k++) e.regs[k*N +: N] = m_out[k];
      e.wrp = m_wrp;
      e.rdp = m_rdp;
      e.inp = m_inp;
      e.irq = m_irq;
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk += 5;
         if (out_regs !== e.regs) begin
            n_err++;
            $display("FAIL sb_out_regs t=%0t got=%h exp=%h", $time, out_regs, e.regs);
         end
         if (out_wr_pulse !== e.wrp) begin
            n_err++;
            $display("FAIL sb_out_wr_pulse t=%0t got=%h exp=%h", $time, out_wr_pulse, e.wrp);
         end
         if (in_rd_pulse !== e.rdp) begin
            n_err++;
            $display("FAIL sb_in_rd_pulse t=%0t got=%h exp=%h", $time, in_rd_pulse, e.rdp);
         end
         if (in_port !== e.inp) begin
            n_err++;
            $display("FAIL sb_in_port t=%0t got=%h exp=%h", $time, in_port, e.inp);
         end
         if (interrupt !== e.irq) begin
            n_err++;
            $display("FAIL sb_interrupt t=%0t got=%b exp=%b", $time, interrupt, e.irq);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, expv);
      end
   endtask

   task automatic cyc(input logic ws, input logic kws, input logic rs, input logic ack,
                      input logic [7:0] pid, input logic [7:0] dat);
      write_strobe   = ws;
      k_write_strobe = kws;
      read_strobe    = rs;
      interrupt_ack  = ack;
      port_id        = pid;
      out_port       = dat;
      step();
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
      read_strobe    = 1'b0;
      interrupt_ack  = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NUM_OUT; k++) m_out[k] = '0;
      reset = 1'b1; port_id = '0; out_port = '0;
      write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
      interrupt_ack = 1'b0; in_ports = '0; irq_src = '0;

      repeat (3) cyc(0, 0, 0, 0, 8'h00, 8'h00);
      chk("reset_out_regs_lo", out_regs[31:0], 32'h0);
      chk("reset_interrupt", {31'b0, interrupt}, 32'h0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, 8'h00, 8'h00);

      // plain write, then pulse must be gone
      cyc(1, 0, 0, 0, 8'h03, 8'hA5);
      chk("wr_port3", {24'b0, out_regs[3*N +: N]}, 32'hA5);
      chk("wr_pulse", {16'b0, out_wr_pulse}, 32'h0008);
      chk("wr_port0_untouched", {24'b0, out_regs[0 +: N]}, 32'h0);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      chk("wr_pulse_one_cycle", {16'b0, out_wr_pulse}, 32'h0);

      // constant-port write aliases 0x13 onto port 3; full decode ignores it
      cyc(0, 1, 0, 0, 8'h13, 8'h5A);
      chk("kwr_port3", {24'b0, out_regs[3*N +: N]}, 32'h5A);
      cyc(1, 0, 0, 0, 8'h13, 8'h77);
      chk("wr_unmapped_pulse", {16'b0, out_wr_pulse}, 32'h0);
      chk("wr_unmapped_port3", {24'b0, out_regs[3*N +: N]}, 32'h5A);

      // input read path
      in_ports[2*N +: N] = 8'h3C;
      cyc(0, 0, 1, 0, 8'h02, 8'h00);
      chk("rd_port2", {24'b0, in_port}, 32'h3C);
      chk("rd_pulse", {24'b0, in_rd_pulse}, 32'h04);
      cyc(0, 0, 0, 0, 8'h80, 8'h00);
      chk("rd_unmapped", {24'b0, in_port}, 32'h0);
      chk("rd_pulse_one_cycle", {24'b0, in_rd_pulse}, 32'h0);

      // interrupt: mask, edge, ack, clear
      cyc(1, 0, 0, 0, 8'hF1, 8'h05);
      irq_src = 4'b0001;
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("irq_not_yet", {31'b0, interrupt}, 32'h0);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("irq_high_t2", {31'b0, interrupt}, 32'h1);
      chk("irq_pending_read", {24'b0, in_port}, 32'h01);
      cyc(0, 0, 0, 1, 8'hF1, 8'h00);
      chk("irq_ack_low", {31'b0, interrupt}, 32'h0);
      chk("mask_read", {24'b0, in_port}, 32'h05);
      cyc(1, 0, 0, 0, 8'hF2, 8'h01);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("w1c_pending", {24'b0, in_port}, 32'h00);
      chk("w1c_irq_low", {31'b0, interrupt}, 32'h0);

      // unmasked edge stays invisible to interrupt
      irq_src = 4'b0011;
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("unmasked_pending", {24'b0, in_port}, 32'h02);
      chk("unmasked_no_irq", {31'b0, interrupt}, 32'h0);

      // set wins over simultaneous clear
      irq_src = 4'b0000;
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      irq_src = 4'b0001;
      cyc(1, 0, 0, 0, 8'hF2, 8'h01);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("set_beats_w1c", {24'b0, in_port}, 32'h03);
      chk("irq_after_set", {31'b0, interrupt}, 32'h1);

      // reset with state present; source held high through reset
      reset = 1'b1;
      cyc(1, 0, 0, 0, 8'h05, 8'hFF);
      chk("rst_out_regs", out_regs[63:32] | out_regs[31:0], 32'h0);
      chk("rst_irq", {31'b0, interrupt}, 32'h0);
      chk("rst_wr_pulse", {16'b0, out_wr_pulse}, 32'h0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("post_rst_edge", {24'b0, in_port}, 32'h01);
      cyc(0, 0, 0, 0, 8'hF0, 8'h00);
      chk("post_rst_single_edge", {24'b0, in_port}, 32'h01);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] pid;
         int sel;
         reset = ($urandom_range(0, 99) == 0);
         case ($urandom_range(0, 5))
            0: pid = 8'($urandom_range(0, NUM_OUT + 3));
            1: pid = 8'($urandom_range(8'hF0, 8'hF3));
            2: pid = 8'h10 | 8'($urandom_range(0, 15));
            3: pid = 8'($urandom);
            4: pid = 8'($urandom_range(0, NUM_IN - 1));
            default: pid = 8'hF1;
         endcase
         if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (4'b0001 << $urandom_range(0, NUM_IRQ - 1));
         if ((i % 16) == 0) in_ports = {$urandom, $urandom};
         sel = $urandom_range(0, 3);
         cyc(sel == 0, sel == 1, sel == 2, $urandom_range(0, 15) == 0, pid, 8'($urandom));
      end
      reset = 1'b0;
      cyc(0, 0, 0, 0, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
